// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch/decode boundary of the RISC-V core.
package riscv_pkg;

  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam int          FD_XLEN      = 32;

  typedef struct packed {
    logic [31:0]        instr;
    logic [FD_XLEN-1:0] pc;
    logic [FD_XLEN-1:0] pc_plus4;
  } fd_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fd_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// state | meaning
// EMPTY | no entries held
// ONE   | main entry valid, presented downstream
// TWO   | main + skid valid, upstream stalled
module pipe_skid_buf
  import riscv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  fd_state_e      state, state_nx;
  logic [W-1:0]   main_q, skid_q;
  logic           load_main, load_skid, main_from_skid;
  logic           in_xfer, out_xfer;

  // Both handshakes come from the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nx  = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (out_xfer) begin
            state_nx = EMPTY;
          end else if (in_xfer) begin
            state_nx  = TWO;
            load_skid = 1'b1;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_nx       = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      if (load_main)           main_q <= in_data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch-to-decode pipeline register: skid-buffered valid/ready stage with
// NOP substitution on empty slots and a saturating back-pressure counter.
module fd_pipe_reg
  import riscv_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_plus4,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PW = 32 + 2 * XLEN;

  logic [PW-1:0] in_data, out_data;

  assign in_data = {in_instr, in_pc, in_pc_plus4};

  pipe_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // PC fields keep the last held entry when empty; only the instruction becomes a bubble.
  assign out_instr    = out_valid ? out_data[PW-1 -: 32] : NOP_INSTR;
  assign out_pc       = out_data[2*XLEN-1 -: XLEN];
  assign out_pc_plus4 = out_data[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
